// File: rtl/cla_seq_adder.sv
// rtl/cla_seq_adder.sv - sequential adder resolving CHUNK bits per cycle through a generate/propagate carry chain
module cla_seq_adder #(
    parameter int WIDTH = 32,
    parameter int CHUNK = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             c_in,
    output logic             ready,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             c_out,
    output logic             ovf
);
    localparam int CHUNK_SAFE = (CHUNK < 1) ? 1 : CHUNK;
    localparam int NCHUNK     = WIDTH / CHUNK_SAFE;
    localparam int IDXW       = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;
    localparam logic [WIDTH-1:0] CHUNK_MASK = WIDTH'({CHUNK_SAFE{1'b1}});

    if (CHUNK < 1 || WIDTH < CHUNK || (WIDTH % CHUNK_SAFE) != 0) begin : g_bad_params
        $error("cla_seq_adder: WIDTH must be a nonzero multiple of CHUNK");
    end

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } state_t;

    state_t                state_q;
    state_t                state_d;
    logic                  accept;
    logic                  last_chunk;
    logic [WIDTH-1:0]      a_q;
    logic [WIDTH-1:0]      b_q;
    logic                  cin_q;
    logic [IDXW-1:0]       idx_q;
    logic                  carry_q;
    logic [WIDTH-1:0]      sum_q;
    logic                  c_out_q;
    logic                  ovf_q;

    logic [31:0]           base;
    logic [CHUNK_SAFE-1:0] a_ch;
    logic [CHUNK_SAFE-1:0] b_ch;
    logic [CHUNK_SAFE-1:0] p;
    logic [CHUNK_SAFE-1:0] g;
    logic [CHUNK_SAFE-1:0] s_ch;
    logic [CHUNK_SAFE:0]   c;
    logic [WIDTH-1:0]      sum_d;

    assign last_chunk = (idx_q == IDXW'(NCHUNK - 1));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        ready   = 1'b0;
        busy    = 1'b0;
        done    = 1'b0;
        accept  = 1'b0;
        case (state_q)
            IDLE: begin
                ready = 1'b1;
                if (start) begin
                    accept  = 1'b1;
                    state_d = RUN;
                end
            end
            RUN: begin
                busy = 1'b1;
                if (last_chunk) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                done    = 1'b1;
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Ripple through the current chunk; chunk 0 takes the latched carry-in.
    always_comb begin
        base  = 32'(idx_q) * 32'(CHUNK_SAFE);
        a_ch  = CHUNK_SAFE'(a_q >> base);
        b_ch  = CHUNK_SAFE'(b_q >> base);
        p     = a_ch ^ b_ch;
        g     = a_ch & b_ch;
        c     = '0;
        s_ch  = '0;
        c[0]  = (idx_q == '0) ? cin_q : carry_q;
        for (int i = 0; i < CHUNK_SAFE; i++) begin
            c[i+1]  = g[i] | (p[i] & c[i]);
            s_ch[i] = p[i] ^ c[i];
        end
        sum_d = (sum_q & ~(CHUNK_MASK << base)) | (WIDTH'(s_ch) << base);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            a_q     <= '0;
            b_q     <= '0;
            cin_q   <= 1'b0;
            idx_q   <= '0;
            carry_q <= 1'b0;
            sum_q   <= '0;
            c_out_q <= 1'b0;
            ovf_q   <= 1'b0;
        end else if (accept) begin
            a_q     <= a;
            b_q     <= b;
            cin_q   <= c_in;
            idx_q   <= '0;
            carry_q <= 1'b0;
            sum_q   <= '0;
            c_out_q <= 1'b0;
            ovf_q   <= 1'b0;
        end else if (state_q == RUN) begin
            sum_q   <= sum_d;
            carry_q <= c[CHUNK_SAFE];
            idx_q   <= idx_q + IDXW'(1);
            if (last_chunk) begin
                c_out_q <= c[CHUNK_SAFE];
                ovf_q   <= c[CHUNK_SAFE-1] ^ c[CHUNK_SAFE];
            end
        end
    end

    assign sum   = sum_q;
    assign c_out = c_out_q;
    assign ovf   = ovf_q;

endmodule

// File: tb/tb_cla_seq_adder.sv
// tb/tb_cla_seq_adder.sv - scoreboard bench for cla_seq_adder, with CHUNK sweep instances
module tb_cla_seq_adder;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic        start_s = 1'b0;
    logic [31:0] a = '0;
    logic [31:0] b = '0;
    logic        c_in = 1'b0;

    logic        ready, busy, done, c_out, ovf;
    logic [31:0] sum;
    logic        rdy_c1, bsy_c1, done_c1, c_out_c1, ovf_c1;
    logic [31:0] sum_c1;
    logic        rdy_c4, bsy_c4, done_c4, c_out_c4, ovf_c4;
    logic [31:0] sum_c4;
    logic        rdy_c32, bsy_c32, done_c32, c_out_c32, ovf_c32;
    logic [31:0] sum_c32;

    always #5 clk = ~clk;

    cla_seq_adder #(.WIDTH(32), .CHUNK(8)) dut (
        .clk(clk), .rst(rst), .start(start), .a(a), .b(b), .c_in(c_in),
        .ready(ready), .busy(busy), .done(done), .sum(sum), .c_out(c_out), .ovf(ovf)
    );
    cla_seq_adder #(.WIDTH(32), .CHUNK(1)) dut_c1 (
        .clk(clk), .rst(rst), .start(start_s), .a(a), .b(b), .c_in(c_in),
        .ready(rdy_c1), .busy(bsy_c1), .done(done_c1), .sum(sum_c1), .c_out(c_out_c1), .ovf(ovf_c1)
    );
    cla_seq_adder #(.WIDTH(32), .CHUNK(4)) dut_c4 (
        .clk(clk), .rst(rst), .start(start_s), .a(a), .b(b), .c_in(c_in),
        .ready(rdy_c4), .busy(bsy_c4), .done(done_c4), .sum(sum_c4), .c_out(c_out_c4), .ovf(ovf_c4)
    );
    cla_seq_adder #(.WIDTH(32), .CHUNK(32)) dut_c32 (
        .clk(clk), .rst(rst), .start(start_s), .a(a), .b(b), .c_in(c_in),
        .ready(rdy_c32), .busy(bsy_c32), .done(done_c32), .sum(sum_c32), .c_out(c_out_c32), .ovf(ovf_c32)
    );

    typedef logic [33:0] res_t;  // {ovf, c_out, sum}

    res_t sb[$];
    int   n_cmp = 0;
    int   n_bad = 0;
    int   cyc = 0;
    int   lat = -1;
    int   last_done = -1;
    int   done_cnt = 0;
    bit   b2b = 1'b0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed 0x%0h required 0x%0h", tag, obs, exp);
        end
    endtask

    function automatic res_t model(input logic [31:0] x, input logic [31:0] y, input logic ci);
        logic [32:0] t;
        logic        v;
        t = {1'b0, x} + {1'b0, y} + {32'd0, ci};
        v = (x[31] == y[31]) && (t[31] != x[31]);
        return {v, t};
    endfunction

    task automatic wait_done(input int budget);
        int c0;
        c0 = done_cnt;
        for (int i = 0; i < budget && done_cnt == c0; i++) begin
            @(posedge clk);
            #1;
        end
        chk("done_within_budget", 64'(done_cnt != c0), 64'd1);
    endtask

    always @(negedge clk) begin
        res_t r;
        cyc++;
        if (lat >= 0) lat++;
        if (rst) begin
            sb.delete();
            lat = -1;
        end else begin
            chk("one_hot", 64'($countones({ready, busy, done})), 64'd1);
            if (done) begin
                done_cnt++;
                if (sb.size() == 0) begin
                    chk("done_without_request", 64'(done), 64'd0);
                end else begin
                    r = sb.pop_front();
                    chk("sum", 64'(sum), 64'(r[31:0]));
                    chk("c_out", 64'(c_out), 64'(r[32]));
                    chk("ovf", 64'(ovf), 64'(r[33]));
                    chk("latency", 64'(lat), 64'd5);
                end
                if (b2b && last_done >= 0) chk("issue_interval", 64'(cyc - last_done), 64'd6);
                last_done = cyc;
                lat = -1;
            end
            if (start && ready) begin
                sb.push_back(model(a, b, c_in));
                lat = 0;
            end
        end
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int c0;
        int lat_s [3];

        repeat (2) @(posedge clk);
        #1;
        chk("rst_ready", 64'(ready), 64'd1);
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_done", 64'(done), 64'd0);
        chk("rst_sum", 64'(sum), 64'd0);
        chk("rst_c_out", 64'(c_out), 64'd0);
        chk("rst_ovf", 64'(ovf), 64'd0);

        rst = 1'b0;
        a = 32'hFFFF_FFFF; b = 32'h0; c_in = 1'b1; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        chk("first_start_accepted", 64'(busy), 64'd1);
        wait_done(20);
        chk("hold_sum", 64'(sum), 64'h0);
        chk("hold_c_out", 64'(c_out), 64'd1);

        a = 32'h7FFF_FFFF; b = 32'h0000_0001; c_in = 1'b0; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        wait_done(20);
        chk("hold_ovf", 64'(ovf), 64'd1);
        chk("hold_sum_ovf", 64'(sum), 64'h8000_0000);

        a = 32'h1234_5678; b = 32'h0FED_CBA8; c_in = 1'b0; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        chk("sum_cleared_on_accept", 64'(sum), 64'h0);
        c0 = done_cnt;
        @(posedge clk); #1;
        chk("partial_sum_chunk0", 64'(sum), 64'h20);
        a = 32'hDEAD_BEEF; b = 32'hCAFE_F00D; c_in = 1'b1; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (10) @(posedge clk);
        #1;
        chk("single_done_pulse", 64'(done_cnt - c0), 64'd1);

        a = 32'h0000_0001; b = 32'h0000_0002; c_in = 1'b0; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        @(posedge clk);
        @(posedge clk);
        #3;
        rst = 1'b1;
        #1;
        chk("abort_sum", 64'(sum), 64'h0);
        chk("abort_busy", 64'(busy), 64'd0);
        chk("abort_ready", 64'(ready), 64'd1);
        @(posedge clk); #1;
        rst = 1'b0;
        c0 = done_cnt;
        repeat (8) @(posedge clk);
        #1;
        chk("no_done_after_abort", 64'(done_cnt - c0), 64'd0);
        a = 32'h0000_0003; b = 32'h0000_0004; c_in = 1'b1; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        wait_done(20);

        last_done = -1;
        b2b = 1'b1;
        c0 = done_cnt;
        a = $urandom; b = $urandom; c_in = 1'($urandom); start = 1'b1;
        for (int i = 0; i < 7000 && (done_cnt - c0) < 1000; i++) begin
            @(posedge clk); #1;
            a = ($urandom_range(0, 7) == 0) ? 32'hFFFF_FFFF : 32'($urandom);
            b = ($urandom_range(0, 7) == 0) ? 32'h8000_0000 : 32'($urandom);
            c_in = 1'($urandom);
        end
        start = 1'b0;
        chk("b2b_op_count", 64'(done_cnt - c0), 64'd1000);
        repeat (10) @(posedge clk);
        #1;
        b2b = 1'b0;

        a = 32'hFFFF_FFFF; b = 32'hFFFF_FFFF; c_in = 1'b1; start_s = 1'b1;
        @(posedge clk); #1;
        start_s = 1'b0;
        lat_s = '{-1, -1, -1};
        for (int k = 1; k <= 40; k++) begin
            @(posedge clk); #1;
            if (done_c1 && lat_s[0] < 0) begin
                lat_s[0] = k;
                chk("c1_sum", 64'(sum_c1), 64'hFFFF_FFFF);
                chk("c1_c_out", 64'(c_out_c1), 64'd1);
            end
            if (done_c4 && lat_s[1] < 0) begin
                lat_s[1] = k;
                chk("c4_sum", 64'(sum_c4), 64'hFFFF_FFFF);
                chk("c4_c_out", 64'(c_out_c4), 64'd1);
            end
            if (done_c32 && lat_s[2] < 0) begin
                lat_s[2] = k;
                chk("c32_sum", 64'(sum_c32), 64'hFFFF_FFFF);
                chk("c32_c_out", 64'(c_out_c32), 64'd1);
            end
        end
        chk("c1_latency", 64'(lat_s[0]), 64'd32);
        chk("c4_latency", 64'(lat_s[1]), 64'd8);
        chk("c32_latency", 64'(lat_s[2]), 64'd1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/cla_seq_adder.md
CLA_SEQ_ADDER -- requirements
Module: cla_seq_adder

Interface
REQ-001 Parameter WIDTH, default 32: operand and sum width in bits.
REQ-002 Parameter CHUNK, default 8: bits resolved per cycle by the per-bit generate/propagate carry chain.
REQ-003 clk  input  1  single clock; all state updates on its rising edge.
REQ-004 rst  input  1  reset, asynchronous and active-high.
REQ-005 start  input  1  request to begin an addition; sampled only when ready=1.
REQ-006 a  input  WIDTH  operand A (unsigned or two's complement).
REQ-007 b  input  WIDTH  operand B.
REQ-008 c_in  input  1  carry into bit 0.
REQ-009 ready  output  1  block is IDLE and will accept start.
REQ-010 busy  output  1  an addition is in progress (state RUN).
REQ-011 done  output  1  one-cycle pulse; result outputs are valid.
REQ-012 sum  output  WIDTH  a + b + c_in, modulo 2^WIDTH.
REQ-013 c_out  output  1  carry out of bit WIDTH-1.
REQ-014 ovf  output  1  signed overflow: carry into bit WIDTH-1 XOR c_out.

Function
REQ-015 WIDTH SHALL be a nonzero multiple of CHUNK, and CHUNK SHALL be >= 1; any other combination SHALL fail elaboration.
REQ-016 NCHUNK = WIDTH/CHUNK; the chunk index counter SHALL be ceil(log2(NCHUNK)) bits wide, minimum 1.
REQ-017 The FSM SHALL have exactly three states: IDLE, RUN and DONE.
REQ-018 IDLE: ready=1; start=1 at an edge SHALL latch a, b and c_in, clear the index to 0, and enter RUN.
REQ-019 RUN: each edge SHALL process chunk idx (bits idx*CHUNK .. idx*CHUNK+CHUNK-1), write its sum bits into the sum register, store the chunk carry-out in the carry register, and increment idx.
REQ-020 Per-bit carry within a chunk: P=a^b, G=a&b, c[i+1]=G|(P&c[i]), sum bit=P^c[i]; c[0] of chunk 0 = latched c_in, of chunk k>0 = carry register.
REQ-021 On the edge that processes chunk NCHUNK-1, the block SHALL load c_out and ovf and enter DONE.
REQ-022 DONE: done=1 for exactly one cycle; the next edge SHALL unconditionally enter IDLE.
REQ-023 Latency: done SHALL be high in the cycle that follows the NCHUNK-th edge after the accepting edge (NCHUNK=4 for the defaults).
REQ-024 start while busy=1 or done=1 SHALL be ignored, with no queuing; a, b and c_in changes during RUN SHALL have no effect.
REQ-025 sum, c_out and ovf SHALL hold their last result from DONE until the next accepting edge; sum bits of chunks not yet processed SHALL read 0 after that edge.
REQ-026 Back-to-back operation: start held high SHALL be accepted in the IDLE cycle following DONE, so the minimum issue interval is NCHUNK+2 cycles.
REQ-027 ready, busy and done SHALL be mutually exclusive and exactly one-hot at all times.

Reset
REQ-028 rst=1 SHALL immediately, without a clock edge, force state=IDLE, idx=0, carry register=0, sum=0, c_out=0, ovf=0, done=0, busy=0 and ready=1.
REQ-029 rst asserted during RUN or DONE SHALL abort the operation; no done pulse SHALL follow.
REQ-030 The first start SHALL be accepted on the first rising edge after rst deasserts.

Verification (WIDTH=32, CHUNK=8)
REQ-031 a=0xFFFFFFFF, b=0, c_in=1, start pulse -> after 4 edges, done=1 for 1 cycle; sum=0x00000000, c_out=1, ovf=0.
REQ-032 a=0x7FFFFFFF, b=0x00000001, c_in=0 -> sum=0x80000000, c_out=0, ovf=1.
REQ-033 a=0x12345678, b=0x0FEDCBA8, c_in=0 -> sum=0x22222220, c_out=0, ovf=0; second start pulsed during RUN is ignored (only one done pulse).
REQ-034 rst pulsed asynchronously mid-RUN (after 2 edges) -> sum=0, busy=0, ready=1 at once; no done pulse; a new start then completes correctly.
REQ-035 start held high continuously with random operands for 1000 ops -> done pulses every 6 cycles; every result matches a reference model of {c_out,sum}=a+b+c_in and its ovf.
REQ-036 Parameter sweep CHUNK in {1,4,32} -> latency = NCHUNK edges; 0xFFFFFFFF+0xFFFFFFFF+1 gives sum=0xFFFFFFFF, c_out=1.
